// File: rtl/inst_encoder_loader_if.sv
// Stream of decoded instruction fields in, instruction-memory write port out.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [1:0]        in_funct;
  logic [2:0]        in_ra;
  logic [4:0]        in_rb;
  logic              in_last;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [8:0]        im_wdata;

  modport master (
    output in_valid, in_op, in_funct, in_ra, in_rb, in_last,
    input  in_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    input  in_valid, in_op, in_funct, in_ra, in_rb, in_last,
    output in_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs decoded fields into 9-bit machine words and writes them to
// consecutive instruction-memory addresses from BASE_ADDR.
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      start,
  inst_encoder_loader_if.slave      bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [ADDR_W:0]           count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        word;
  logic              illegal;
  logic              accept;

  assign bus.in_ready = (state == S_RUN);
  assign busy         = (state == S_RUN);
  assign done         = (state == S_DONE);
  assign err          = (state == S_ERR);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (bus.in_op)
      3'b000, 3'b001: begin
        if (bus.in_funct == 2'b00) begin
          word    = {4'b0000, bus.in_ra[1:0], bus.in_rb[2:0]};
          illegal = bus.in_ra[2] || (bus.in_rb[4:3] != 2'b00);
        end else begin
          word    = {2'b00, bus.in_funct, bus.in_rb};
        end
      end
      3'b010, 3'b011, 3'b100, 3'b110: begin
        word    = {bus.in_op, bus.in_ra[0], bus.in_rb};
        illegal = (bus.in_ra[2:1] != 2'b00);
      end
      default: begin
        word    = {bus.in_op, bus.in_ra, bus.in_rb[2:0]};
        illegal = (bus.in_rb[4:3] != 2'b00);
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= S_IDLE;
      ptr          <= PTR_BASE;
      count        <= '0;
      err_code     <= 2'b00;
      bus.im_we    <= 1'b0;
      bus.im_waddr <= PTR_BASE;
      bus.im_wdata <= '0;
    end else begin
      bus.im_we <= 1'b0;
      case (state)
        S_RUN: begin
          if (accept) begin
            if (illegal) begin
              state    <= S_ERR;
              err_code <= 2'b01;
            end else begin
              bus.im_we    <= 1'b1;
              bus.im_wdata <= word;
              bus.im_waddr <= ptr;
              count        <= count + 1'b1;
              // Last slot: pointer saturates; only a final bundle may end cleanly here.
              if (ptr == PTR_LAST) begin
                state <= bus.in_last ? S_DONE : S_ERR;
                if (!bus.in_last) err_code <= 2'b10;
              end else begin
                ptr <= ptr + 1'b1;
                if (bus.in_last) state <= S_DONE;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state    <= S_RUN;
            ptr      <= PTR_BASE;
            count    <= '0;
            err_code <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader with a 4-word memory (ADDR_W=2).
module tb_inst_encoder_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  inst_encoder_loader_if #(.ADDR_W(AW)) bus ();

  inst_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .CLK(clk), .Reset(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [8:0]    data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0, n_pass = 0, n_wr = 0, n_legal = 0;

  logic [1:0]    m_state;
  logic [AW-1:0] m_ptr;
  int            m_count;
  logic [1:0]    m_ec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.im_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(bus.im_waddr), 32'(e.addr));
        chk("wdata", 32'(bus.im_wdata), 32'(e.data));
      end
    end
  end

  function automatic void model_enc(input logic [2:0] op, input logic [1:0] fn,
                                    input logic [2:0] ra, input logic [4:0] rb,
                                    output logic [8:0] w, output logic ill);
    ill = 1'b0;
    if (op == 3'd0 || op == 3'd1) begin
      if (fn == 2'd0) begin
        w   = {2'b00, 2'b00, ra[1:0], rb[2:0]};
        ill = (ra > 3'd3) || (rb > 5'd7);
      end else w = {2'b00, fn, rb[4:0]};
    end else if (op == 3'd5 || op == 3'd7) begin
      w   = {op, ra[2:0], rb[2:0]};
      ill = (rb > 5'd7);
    end else begin
      w   = {op, ra[0], rb[4:0]};
      ill = (ra > 3'd1);
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; bus.in_valid = 1'b0; start = 1'b0;
    step(); step();
    rst = 1'b0;
    m_state = 2'd0; m_ptr = '0; m_count = 0; m_ec = 2'd0;
    exp_q.delete();
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_busy"},  32'(busy),         32'(m_state == 2'd1));
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'(m_state == 2'd1));
    chk({tag, "_done"},  32'(done),         32'(m_state == 2'd2));
    chk({tag, "_err"},   32'(err),          32'(m_state == 2'd3));
    chk({tag, "_ecode"}, 32'(err_code),     32'(m_ec));
    chk({tag, "_count"}, 32'(count),        32'(m_count));
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
    if (m_state != 2'd1) begin
      m_state = 2'd1; m_ptr = '0; m_count = 0; m_ec = 2'd0;
    end
  endtask

  // lit[9] set: expect lit[8:0] as the written word instead of the model's.
  task automatic send(input logic [2:0] op, input logic [1:0] fn, input logic [2:0] ra,
                      input logic [4:0] rb, input logic last, input logic [9:0] lit = 10'h000);
    int t = 0;
    logic [8:0] w;
    logic ill;
    bus.in_op = op; bus.in_funct = fn; bus.in_ra = ra; bus.in_rb = rb; bus.in_last = last;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && t < 20) begin step(); t++; end
    if (bus.in_ready !== 1'b1) begin
      chk("ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    model_enc(op, fn, ra, rb, w, ill);
    if (lit[9]) w = lit[8:0];
    if (ill) begin
      m_state = 2'd3; m_ec = 2'd1;
    end else begin
      n_legal++;
      exp_q.push_back(wr_t'{addr: m_ptr, data: w});
      m_count++;
      if (m_ptr == '1) begin
        m_state = last ? 2'd2 : 2'd3;
        if (!last) m_ec = 2'd2;
      end else begin
        m_ptr = m_ptr + 1'b1;
        if (last) m_state = 2'd2;
      end
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic poke_outside(input string tag);
    bus.in_op = 3'd7; bus.in_funct = 2'd0; bus.in_ra = 3'd1; bus.in_rb = 5'd1; bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    step(); step();
    bus.in_valid = 1'b0;
    chk_status(tag);
  endtask

  task automatic rand_legal(output logic [2:0] op, output logic [1:0] fn,
                            output logic [2:0] ra, output logic [4:0] rb);
    op = 3'($urandom_range(0, 7));
    fn = 2'($urandom_range(0, 3));
    ra = 3'($urandom_range(0, 7));
    rb = 5'($urandom_range(0, 31));
    if (op <= 3'd1 && fn == 2'd0) begin
      ra = 3'($urandom_range(0, 3));
      rb = 5'($urandom_range(0, 7));
    end else if (op == 3'd5 || op == 3'd7) rb = 5'($urandom_range(0, 7));
    else if (op > 3'd1) ra = 3'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [2:0] op, ra;
    logic [1:0] fn;
    logic [4:0] rb;
    int n, gap;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_funct = '0;
    bus.in_ra = '0; bus.in_rb = '0; bus.in_last = 1'b0;

    reset_dut();
    chk_status("rst");
    chk("rst_we",    32'(bus.im_we),    32'd0);
    chk("rst_waddr", 32'(bus.im_waddr), 32'd0);
    chk("rst_wdata", 32'(bus.im_wdata), 32'd0);
    poke_outside("idle_poke");

    // T1
    do_start();
    chk_status("t1_start");
    send(3'd7, 2'd0, 3'd3, 5'd5, 1'b0, {1'b1, 9'h1DD});
    send(3'd5, 2'd0, 3'd0, 5'd1, 1'b1, {1'b1, 9'h141});
    chk("t1_done_with_we", 32'({done, bus.im_we, bus.in_ready}), 32'b110);
    step();
    chk_status("t1_end");
    chk("t1_count", 32'(count), 32'd2);

    // T2
    do_start();
    send(3'd2, 2'd0, 3'd1, 5'h14, 1'b0, {1'b1, 9'h0B4});
    send(3'd0, 2'd0, 3'd2, 5'd6,  1'b0, {1'b1, 9'h016});
    send(3'd0, 2'd1, 3'd0, 5'h1F, 1'b1, {1'b1, 9'h03F});
    step();
    chk_status("t2_end");

    // T3
    do_start();
    send(3'd3, 2'd0, 3'd2, 5'd0, 1'b0);
    chk("t3_no_we", 32'(bus.im_we), 32'd0);
    chk_status("t3_err");
    poke_outside("t3_err_poke");
    do_start();
    chk_status("t3_restart");
    send(3'd7, 2'd0, 3'd1, 5'd1, 1'b1);
    step();
    chk_status("t3_end");

    // T4: overflow, then the same run ending on the final slot
    do_start();
    for (int k = 0; k < 4; k++) send(3'd1, 2'd2, 3'd0, 5'(k + 3), 1'b0);
    step();
    chk_status("t4_ovf");
    do_start();
    for (int k = 0; k < 4; k++) send(3'd6, 2'd0, 3'd1, 5'(k * 7), k == 3);
    step();
    chk_status("t4_last");

    // T5: reset on the edge that would accept drops the write
    do_start();
    send(3'd7, 2'd0, 3'd0, 5'd0, 1'b0);
    bus.in_op = 3'd7; bus.in_ra = 3'd2; bus.in_rb = 5'd2; bus.in_last = 1'b0;
    bus.in_valid = 1'b1; rst = 1'b1;
    step();
    bus.in_valid = 1'b0; rst = 1'b0;
    m_state = 2'd0; m_ptr = '0; m_count = 0; m_ec = 2'd0;
    chk("t5_we",    32'(bus.im_we),    32'd0);
    chk("t5_waddr", 32'(bus.im_waddr), 32'd0);
    chk("t5_wdata", 32'(bus.im_wdata), 32'd0);
    chk_status("t5_rst");
    do_start();
    send(3'd7, 2'd0, 3'd1, 5'd2, 1'b0);
    do_start();
    chk_status("t5_start_ignored");
    send(3'd5, 2'd0, 3'd4, 5'd3, 1'b1);
    step();
    chk_status("t5_end");

    // T6: random gaps and start pulses while busy
    for (int s = 0; s < 4; s++) begin
      do_start();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          if ($urandom_range(0, 3) == 0) do_start();
          else step();
        end
        rand_legal(op, fn, ra, rb);
        send(op, fn, ra, rb, k == n - 1);
      end
      step();
      chk_status("t6");
    end

    step(); step();
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    chk("writes_vs_legal", 32'(n_wr), 32'(n_legal));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
